scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of scanned 7-segment digits (fixed at 6 for this release).
REQ-002 SHALL have port Clk  input  1  system clock, all flops on rising edge.
REQ-003 SHALL have port Rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port Tick_ms  input  1  one-Clk-wide scan strobe, minimum spacing 2 Clk.
REQ-005 SHALL have port Scan_en  input  1  level; 0 forces blanked idle.
REQ-006 SHALL have port Hour, Minute, Second  input  6 each  binary field values, legal 0..59 (Hour 0..23).
REQ-007 SHALL have port Set_mode  input  2  0 none, 1 hour, 2 minute, 3 second field selected for blinking.
REQ-008 SHALL have port Blink_phase  input  1  level; 1 = selected field dark.
REQ-009 SHALL have port Colon_en  input  1  level; enables separator decimal points.
REQ-010 SHALL have port Duan  output  8  segment drive, active-high, bit7=a .. bit1=g, bit0=dp.
REQ-011 SHALL have port Wei  output  6  digit select, one-hot active-high, Wei[i] = digit i.
REQ-012 SHALL have port Frame_start  output  1  one-Clk pulse when digit 0 becomes visible.

Function
REQ-013 Digit map SHALL be: 0 Second ones, 1 Second tens, 2 Minute ones, 3 Minute tens, 4 Hour ones, 5 Hour tens.
REQ-014 FSM SHALL have states IDLE, BLANK, LOAD, SHOW with registered outputs only.
REQ-015 IDLE: Duan=0, Wei=0; on Tick_ms with Scan_en=1 -> LOAD, digit counter=0, snapshot captured.
REQ-016 SHOW: Wei one-hot for current digit held; on Tick_ms -> BLANK.
REQ-017 BLANK (exactly 1 Clk): Duan=0, Wei=0, digit counter advances, 5 wraps to 0; snapshot captured when new digit is 0; -> LOAD.
REQ-018 LOAD (exactly 1 Clk): Duan and Wei computed from snapshot and digit counter; -> SHOW.
REQ-019 Tick_ms in BLANK or LOAD SHALL be ignored (dropped, not queued).
REQ-020 Latency SHALL be: Wei/Duan valid 2 Clk edges after the Tick_ms sampling edge (IDLE) or 3 edges (SHOW, via BLANK).
REQ-021 Snapshot SHALL register Hour, Minute, Second together once per frame; mid-frame input changes SHALL not appear until next frame.
REQ-022 Tens = value/10, ones = value%10, computed on 6-bit snapshot; value >59 SHALL display dash (0000_0010) on both digits of that field.
REQ-023 Digit patterns SHALL be 0 1111_1100, 1 0110_0000, 2 1101_1010, 3 1111_0010, 4 0110_0110, 5 1011_0110, 6 1011_1110, 7 1110_0000, 8 1111_1110, 9 1111_0110.
REQ-024 dp (bit0) SHALL be 1 on digits 2 and 4 when Colon_en=1, else 0.
REQ-025 When Blink_phase=1 and digit belongs to Set_mode field, Duan SHALL be 0 including dp, Wei still driven.
REQ-026 Blink_phase, Set_mode, Colon_en SHALL be sampled live in LOAD (not snapshotted).
REQ-027 Frame_start SHALL pulse in the cycle SHOW is entered with digit 0.
REQ-028 Scan_en=0 in any state SHALL force IDLE next Clk with Duan=0, Wei=0, digit=0; Scan_en has priority over Tick_ms.

Reset
REQ-029 Rst_n low SHALL asynchronously set state IDLE, digit counter 0, snapshot 0, Duan=0, Wei=0, Frame_start=0.
REQ-030 Reset mid-frame SHALL restart at digit 0 on the first Tick_ms after release.

Structure
REQ-031 Shared package SHALL hold segment pattern constants, DASH pattern, DIGITS, and FSM state encoding.
REQ-032 One sub-module seg_decode (4-bit value -> 8-bit pattern, codes 10..15 -> 0) SHALL be instantiated once.

Verification
REQ-033 Reset, Scan_en=1, H=12 M=34 S=56, Colon_en=1, 12 ticks spaced 10 Clk -> Wei sequence 000001..100000 twice, Duan 1011_1110, 1011_0110, 0110_0111, 1111_0010, 1101_1011, 0110_0000; Frame_start twice.
REQ-034 Tick in SHOW -> exactly one Clk with Wei=0, Duan=0 before next digit.
REQ-035 Change Second 56->57 while digit 3 shown -> digits 0..5 finish old frame; 57 appears only after wrap.
REQ-036 Set_mode=2, Blink_phase=1 -> Duan=0 on digits 2,3 only; Blink_phase=0 -> normal.
REQ-037 Minute=63 -> digits 2,3 show 0000_0011 (dash+dp on 2) / 0000_0010.
REQ-038 Scan_en dropped during SHOW, and Rst_n asserted mid-frame -> Wei=0 next Clk / immediately; next tick restarts at Wei=000001.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared constants and FSM encoding for the display scanner
// Contents: segment patterns (bit7=a .. bit1=g, bit0=dp), dash pattern,
// digit count, and the scan FSM state type.
package scan_ctrl_pkg;

    localparam int DIGITS = 6;

    localparam logic [7:0] SEG_0    = 8'b1111_1100;
    localparam logic [7:0] SEG_1    = 8'b0110_0000;
    localparam logic [7:0] SEG_2    = 8'b1101_1010;
    localparam logic [7:0] SEG_3    = 8'b1111_0010;
    localparam logic [7:0] SEG_4    = 8'b0110_0110;
    localparam logic [7:0] SEG_5    = 8'b1011_0110;
    localparam logic [7:0] SEG_6    = 8'b1011_1110;
    localparam logic [7:0] SEG_7    = 8'b1110_0000;
    localparam logic [7:0] SEG_8    = 8'b1111_1110;
    localparam logic [7:0] SEG_9    = 8'b1111_0110;
    localparam logic [7:0] SEG_DASH = 8'b0000_0010;
    localparam logic [7:0] SEG_OFF  = 8'b0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

endpackage

// File: rtl/scan_ctrl_if.sv
// rtl/scan_ctrl_if.sv - time inputs, scan controls and segment/digit drive bundle
// slave modport (scanner): inputs Tick_ms, Scan_en, Hour, Minute, Second,
// Set_mode, Blink_phase, Colon_en; outputs Duan, Wei, Frame_start.
// master modport is the mirror image for the driving side.
interface scan_ctrl_if;
    logic       Tick_ms;
    logic       Scan_en;
    logic [5:0] Hour;
    logic [5:0] Minute;
    logic [5:0] Second;
    logic [1:0] Set_mode;
    logic       Blink_phase;
    logic       Colon_en;
    logic [7:0] Duan;
    logic [5:0] Wei;
    logic       Frame_start;

    modport slave (
        input  Tick_ms, Scan_en, Hour, Minute, Second,
        input  Set_mode, Blink_phase, Colon_en,
        output Duan, Wei, Frame_start
    );

    modport master (
        output Tick_ms, Scan_en, Hour, Minute, Second,
        output Set_mode, Blink_phase, Colon_en,
        input  Duan, Wei, Frame_start
    );
endinterface

// File: rtl/scan_ctrl_seg_decode.sv
// rtl/scan_ctrl_seg_decode.sv - BCD nibble to 7-segment pattern decoder
// Ports: i_val (4-bit digit value), o_seg (8-bit pattern, dp always 0).
// Codes 10..15 decode to all segments off.
module seg_decode
    import scan_ctrl_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [7:0] o_seg
);

    always_comb begin
        case (i_val)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - 6-digit multiplexed 7-segment scan controller
// Ports: Clk, Rst_n (async active-low), bus (scan_ctrl_if.slave: time fields,
// Tick_ms scan strobe, Scan_en, blink/colon controls; Duan segments,
// Wei one-hot digit select, Frame_start pulse).
module scan_ctrl #(
    parameter int DIGITS = scan_ctrl_pkg::DIGITS
) (
    input  logic       Clk,
    input  logic       Rst_n,
    scan_ctrl_if.slave bus
);
    import scan_ctrl_pkg::*;

    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_digit, w_digit_nxt;
    logic [5:0] r_hour, r_min, r_sec;
    logic       w_snap;
    logic [7:0] r_duan, w_duan_nxt;
    logic [5:0] r_wei, w_wei_nxt;
    logic       r_frame_start, w_frame_start_nxt;

    logic [5:0] w_val;
    logic [3:0] w_tens, w_ones, w_nib;
    logic [7:0] w_seg, w_load_duan;
    logic [2:0] w_digit_inc;
    logic       w_dp, w_dark;

    // Digit pairs map to fields: 0,1 seconds; 2,3 minutes; 4,5 hours.
    always_comb begin
        case (r_digit[2:1])
            2'd0:    w_val = r_sec;
            2'd1:    w_val = r_min;
            default: w_val = r_hour;
        endcase
    end

    assign w_tens = 4'(w_val / 6'd10);
    assign w_ones = 4'(w_val % 6'd10);
    assign w_nib  = r_digit[0] ? w_tens : w_ones;

    seg_decode u_seg_decode (
        .i_val (w_nib),
        .o_seg (w_seg)
    );

    // Set_mode 3/2/1 selects seconds/minutes/hours, i.e. field index 3 - mode.
    assign w_dp   = bus.Colon_en && (r_digit == 3'd2 || r_digit == 3'd4);
    assign w_dark = bus.Blink_phase && (bus.Set_mode != 2'd0)
                    && (bus.Set_mode == (2'd3 - r_digit[2:1]));
    assign w_load_duan = w_dark ? SEG_OFF
                       : (((w_val > 6'd59) ? SEG_DASH : w_seg) | {7'd0, w_dp});

    assign w_digit_inc = (r_digit == LAST_DIGIT) ? 3'd0 : r_digit + 3'd1;

    // Outputs are registered from the state being left: SHOW keeps the
    // digit lit through the tick edge, BLANK produces the single dark cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_digit_nxt       = r_digit;
        w_snap            = 1'b0;
        w_duan_nxt        = r_duan;
        w_wei_nxt         = r_wei;
        w_frame_start_nxt = 1'b0;
        if (!bus.Scan_en) begin
            w_state_nxt = ST_IDLE;
            w_digit_nxt = 3'd0;
            w_duan_nxt  = SEG_OFF;
            w_wei_nxt   = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_duan_nxt = SEG_OFF;
                    w_wei_nxt  = 6'd0;
                    if (bus.Tick_ms) begin
                        w_state_nxt = ST_LOAD;
                        w_digit_nxt = 3'd0;
                        w_snap      = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (bus.Tick_ms) begin
                        w_state_nxt = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    w_state_nxt = ST_LOAD;
                    w_digit_nxt = w_digit_inc;
                    w_snap      = (w_digit_inc == 3'd0);
                    w_duan_nxt  = SEG_OFF;
                    w_wei_nxt   = 6'd0;
                end
                ST_LOAD: begin
                    w_state_nxt       = ST_SHOW;
                    w_duan_nxt        = w_load_duan;
                    w_wei_nxt         = 6'd1 << r_digit;
                    w_frame_start_nxt = (r_digit == 3'd0);
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= ST_IDLE;
            r_digit       <= 3'd0;
            r_hour        <= 6'd0;
            r_min         <= 6'd0;
            r_sec         <= 6'd0;
            r_duan        <= SEG_OFF;
            r_wei         <= 6'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_digit       <= w_digit_nxt;
            r_duan        <= w_duan_nxt;
            r_wei         <= w_wei_nxt;
            r_frame_start <= w_frame_start_nxt;
            if (w_snap) begin
                r_hour <= bus.Hour;
                r_min  <= bus.Minute;
                r_sec  <= bus.Second;
            end
        end
    end

    assign bus.Duan        = r_duan;
    assign bus.Wei         = r_wei;
    assign bus.Frame_start = r_frame_start;

endmodule

// File: tb/tb_scan_ctrl.sv
// tb/tb_scan_ctrl.sv - self-checking bench for scan_ctrl
module tb_scan_ctrl;

    logic Clk;
    logic Rst_n;
    scan_ctrl_if bus();

    scan_ctrl #(.DIGITS(6)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int fs_count = 0;

    localparam logic [7:0] SEG_TAB [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                           8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    localparam logic [7:0] T33 [6] = '{8'hBE, 8'hB6, 8'h67, 8'hF2, 8'hDB, 8'h60};
    localparam logic [7:0] T36 [6] = '{8'hBE, 8'hB6, 8'h00, 8'h00, 8'hDB, 8'h60};
    localparam logic [7:0] T37 [6] = '{8'hBE, 8'hB6, 8'h03, 8'h02, 8'hDB, 8'h60};
    localparam logic [7:0] T35 [8] = '{8'hBE, 8'hB6, 8'h67, 8'hF2, 8'hDB, 8'h60,
                                       8'hE0, 8'hB6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What a digit must look like, straight from the display rules.
    function automatic logic [7:0] exp_seg(input int d, input int h, input int m,
                                           input int s, input int mode,
                                           input bit blink, input bit colon);
        int f;
        int v;
        logic [7:0] seg;
        f = d / 2;
        v = (f == 0) ? s : (f == 1) ? m : h;
        if (v > 59) seg = 8'h02;
        else        seg = SEG_TAB[(d % 2 == 1) ? v / 10 : v % 10];
        if (colon && (d == 2 || d == 4)) seg[0] = 1'b1;
        if (blink && mode == 3 - f) seg = 8'h00;
        return seg;
    endfunction

    // Reference: m_cd counts edges until the next digit becomes visible
    // (2 from a lit digit, 1 from idle); 0 means a digit is lit or idle.
    bit         m_active;
    int         m_cd, m_digit, m_h, m_m, m_s;
    logic [7:0] e_duan;
    logic [5:0] e_wei;
    logic       e_fs;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_active <= 1'b0; m_cd <= 0; m_digit <= 0;
            m_h <= 0; m_m <= 0; m_s <= 0;
            e_duan <= 8'h00; e_wei <= 6'd0; e_fs <= 1'b0;
        end else begin
            e_fs <= 1'b0;
            if (!bus.Scan_en) begin
                m_active <= 1'b0; m_cd <= 0; m_digit <= 0;
                e_duan <= 8'h00; e_wei <= 6'd0;
            end else if (!m_active) begin
                if (bus.Tick_ms) begin
                    m_active <= 1'b1; m_cd <= 1; m_digit <= 0;
                    m_h <= int'(bus.Hour); m_m <= int'(bus.Minute); m_s <= int'(bus.Second);
                end
            end else if (m_cd == 2) begin
                m_cd <= 1;
                m_digit <= (m_digit + 1) % 6;
                if ((m_digit + 1) % 6 == 0) begin
                    m_h <= int'(bus.Hour); m_m <= int'(bus.Minute); m_s <= int'(bus.Second);
                end
                e_duan <= 8'h00; e_wei <= 6'd0;
            end else if (m_cd == 1) begin
                m_cd   <= 0;
                e_wei  <= 6'd1 << m_digit;
                e_duan <= exp_seg(m_digit, m_h, m_m, m_s, int'(bus.Set_mode),
                                  bus.Blink_phase, bus.Colon_en);
                e_fs   <= (m_digit == 0);
            end else if (bus.Tick_ms) begin
                m_cd <= 2;
            end
        end
    end

    always begin
        @(negedge Clk);
        #1;
        if (cmp_en) begin
            chk("duan", {24'd0, bus.Duan}, {24'd0, e_duan});
            chk("wei", {26'd0, bus.Wei}, {26'd0, e_wei});
            chk("frame_start", {31'd0, bus.Frame_start}, {31'd0, e_fs});
        end
    end

    always @(negedge Clk) if (bus.Frame_start === 1'b1) fs_count++;

    // One tick, then about 10 clocks; reports the final digit and the
    // number of dark cycles seen after the tick.
    task automatic step_digit(output logic [5:0] w, output logic [7:0] d, output int zeros);
        zeros = 0;
        @(negedge Clk); bus.Tick_ms = 1'b1;
        @(negedge Clk); bus.Tick_ms = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk); #2;
            if (bus.Wei == 6'd0) zeros++;
        end
        w = bus.Wei;
        d = bus.Duan;
    endtask

    initial begin
        logic [5:0] w;
        logic [7:0] d;
        int zeros;
        int fs0;

        bus.Tick_ms = 1'b0; bus.Scan_en = 1'b1;
        bus.Hour = 6'd12; bus.Minute = 6'd34; bus.Second = 6'd56;
        bus.Set_mode = 2'd0; bus.Blink_phase = 1'b0; bus.Colon_en = 1'b1;
        Rst_n = 1'b1;
        #3 Rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge Clk);
        #2;
        chk("reset_duan", {24'd0, bus.Duan}, 32'd0);
        chk("reset_wei", {26'd0, bus.Wei}, 32'd0);
        chk("reset_fs", {31'd0, bus.Frame_start}, 32'd0);
        @(negedge Clk); Rst_n = 1'b1;

        fs0 = fs_count;
        for (int i = 0; i < 12; i++) begin
            step_digit(w, d, zeros);
            chk("frame_wei", {26'd0, w}, {26'd0, 6'd1 << (i % 6)});
            chk("frame_duan", {24'd0, d}, {24'd0, T33[i % 6]});
            if (i > 0) chk("blank_gap", zeros, 1);
        end
        chk("frame_start_count", fs_count - fs0, 2);

        bus.Set_mode = 2'd2; bus.Blink_phase = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_digit(w, d, zeros);
            chk("blink_duan", {24'd0, d}, {24'd0, T36[i]});
            chk("blink_wei", {26'd0, w}, {26'd0, 6'd1 << i});
        end

        bus.Blink_phase = 1'b0; bus.Minute = 6'd63;
        for (int i = 0; i < 6; i++) begin
            step_digit(w, d, zeros);
            chk("dash_duan", {24'd0, d}, {24'd0, T37[i]});
        end

        bus.Minute = 6'd34;
        for (int i = 0; i < 8; i++) begin
            step_digit(w, d, zeros);
            chk("snapshot_duan", {24'd0, d}, {24'd0, T35[i]});
            if (i == 3) bus.Second = 6'd57;
        end

        @(negedge Clk); bus.Scan_en = 1'b0;
        @(negedge Clk); #2;
        chk("scan_off_wei", {26'd0, bus.Wei}, 32'd0);
        chk("scan_off_duan", {24'd0, bus.Duan}, 32'd0);
        bus.Scan_en = 1'b1;
        step_digit(w, d, zeros);
        chk("restart_wei", {26'd0, w}, 32'd1);
        step_digit(w, d, zeros);
        step_digit(w, d, zeros);
        chk("mid_wei", {26'd0, w}, 32'd4);
        @(negedge Clk); Rst_n = 1'b0;
        #2;
        chk("async_reset_wei", {26'd0, bus.Wei}, 32'd0);
        @(negedge Clk); Rst_n = 1'b1;
        step_digit(w, d, zeros);
        chk("post_reset_wei", {26'd0, w}, 32'd1);
        chk("post_reset_duan", {24'd0, d}, 32'hE0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge Clk);
            bus.Tick_ms = !bus.Tick_ms && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) bus.Scan_en = 1'b0;
            else if (!bus.Scan_en && $urandom_range(0, 3) == 0) bus.Scan_en = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                bus.Hour   = 6'($urandom_range(0, 63));
                bus.Minute = 6'($urandom_range(0, 63));
                bus.Second = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 29) == 0) begin
                bus.Set_mode    = 2'($urandom_range(0, 3));
                bus.Blink_phase = 1'($urandom_range(0, 1));
                bus.Colon_en    = 1'($urandom_range(0, 1));
            end
            Rst_n = ($urandom_range(0, 999) != 0);
        end
        @(negedge Clk); Rst_n = 1'b1; bus.Tick_ms = 1'b0;
        repeat (2) @(negedge Clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
